// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative 32-step MULT/MULTU/DIV/DIVU engine with busy/done handshake
package selector;
  typedef enum logic [1:0] {MULDIV_MULT, MULDIV_MULTU, MULDIV_DIV, MULDIV_DIVU} muldiv_e;
endpackage

module muldiv_sequencer
  import selector::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  muldiv_e          funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opb_q, opb_d, hi_q, hi_d, lo_q, lo_d;
  logic div_q, div_d, negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;
  logic sgn, is_div;
  logic [WIDTH-1:0] abs_a, abs_b, rem, quo;
  logic [WIDTH:0] msum, dtrial;
  logic [2*WIDTH-1:0] mstep, dstep, prod;
  assign is_div = funct[1];
  assign sgn = ~funct[0];
  assign abs_a = (sgn && a[WIDTH-1]) ? -a : a;
  assign abs_b = (sgn && b[WIDTH-1]) ? -b : b;
  // acc holds {product_hi, multiplier} for multiply and {remainder, dividend/quotient} for divide
  assign msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? opb_q : {WIDTH{1'b0}}};
  assign mstep = {msum, acc_q[WIDTH-1:1]};
  assign dtrial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
  assign dstep = dtrial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                               : {dtrial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign rem = acc_q[2*WIDTH-1:WIDTH];
  assign quo = acc_q[WIDTH-1:0];
  assign prod = negq_q ? -acc_q : acc_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    opb_d = opb_q;
    div_d = div_q;
    negq_d = negq_q;
    negr_d = negr_q;
    dz_d = dz_q;
    hi_d = hi_q;
    lo_d = lo_q;
    if (flush && state_q != IDLE) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: if (start && !flush) begin
          div_d = is_div;
          dz_d = is_div && b == '0;
          // divide-by-zero preloads its fixed result and is frozen through CALC
          acc_d = (is_div && b == '0) ? {a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, abs_a};
          opb_d = abs_b;
          negq_d = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
          negr_d = sgn & a[WIDTH-1];
          cnt_d = CW'(WIDTH - 1);
          state_d = CALC;
        end
        CALC: begin
          acc_d = dz_q ? acc_q : div_q ? dstep : mstep;
          cnt_d = cnt_q - 1'b1;
          state_d = cnt_q == '0 ? SIGN : CALC;
        end
        SIGN: begin
          {hi_d, lo_d} = dz_q ? acc_q : !div_q ? prod
                       : {negr_q ? -rem : rem, negq_q ? -quo : quo};
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      opb_q <= '0;
      div_q <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      dz_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      opb_q <= opb_d;
      div_q <= div_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      dz_q <= dz_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed table, corner sequences and random ops against an arithmetic model
module tb_muldiv_sequencer;
  import selector::*;
  logic clk = 0, reset_n = 0, start = 0, flush = 0;
  muldiv_e funct = MULDIV_MULT;
  logic [31:0] a = 0, b = 0;
  logic busy, done;
  logic [31:0] hi, lo;
  int errs = 0, checks = 0;
  typedef struct {
    muldiv_e f;
    logic [31:0] a, b, hi, lo;
  } vec_t;
  vec_t vt[10];

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .funct(funct), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input muldiv_e f, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = $signed(x);
    sy = $signed(y);
    if (f == MULDIV_MULT) res = sx * sy;
    else if (f == MULDIV_MULTU) res = {32'b0, x} * {32'b0, y};
    else if (y == 0) res = {x, 32'hFFFFFFFF};
    else if (f == MULDIV_DIV) begin
      q = sx / sy;
      r = sx % sy;
      res = {r[31:0], q[31:0]};
    end else res = {x % y, x / y};
    return res;
  endfunction

  // Starts one op, then watches 40 cycles; cycle c is the c-th cycle after the start edge.
  task automatic run_op(input muldiv_e f, input logic [31:0] x, input logic [31:0] y,
                        input int restart_at, input int flush_at, input int rst_at,
                        output int first, output int bcnt, output int dcnt,
                        output logic [63:0] res, output logic [65:0] snap);
    @(negedge clk);
    funct = f; a = x; b = y; start = 1;
    @(posedge clk); #1;
    start = 0;
    funct = muldiv_e'(2'($urandom_range(0, 3)));
    a = $urandom; b = $urandom;
    first = 0; bcnt = 0; dcnt = 0; res = 'x; snap = 'x;
    for (int c = 1; c <= 40; c++) begin
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (first == 0) begin first = c; res = {hi, lo}; end
      end
      if (c == flush_at + rst_at + 1) snap = {busy, done, hi, lo};
      start = (c == restart_at);
      flush = (c == flush_at);
      reset_n = !(c == rst_at);
      @(posedge clk); #1;
    end
    start = 0; flush = 0; reset_n = 1;
  endtask

  task automatic normal(input string name, input muldiv_e f, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] exp, input int restart_at);
    int first, bcnt, dcnt;
    logic [63:0] res;
    logic [65:0] snap;
    run_op(f, x, y, restart_at, 0, 0, first, bcnt, dcnt, res, snap);
    chk({name, " latency"}, 64'(first), 64'd34);
    chk({name, " busy cycles"}, 64'(bcnt), 64'd34);
    chk({name, " done count"}, 64'(dcnt), 64'd1);
    chk({name, " hi:lo"}, res, exp);
  endtask

  initial begin
    int first, bcnt, dcnt, d;
    logic [63:0] res, prior;
    logic [65:0] snap;
    muldiv_e f;
    logic [31:0] x, y;
    vt[0] = '{MULDIV_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vt[1] = '{MULDIV_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vt[2] = '{MULDIV_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0};
    vt[3] = '{MULDIV_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[4] = '{MULDIV_DIVU, 32'd100, 32'd7, 32'd2, 32'd14};
    vt[5] = '{MULDIV_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000};
    vt[6] = '{MULDIV_DIV, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF};
    vt[7] = '{MULDIV_DIVU, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF};
    vt[8] = '{MULDIV_DIV, 32'h80000001, 32'h0, 32'h80000001, 32'hFFFFFFFF};
    vt[9] = '{MULDIV_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD};

    // reset with start asserted: reset must win
    reset_n = 0; start = 1; funct = MULDIV_MULTU; a = 5; b = 6;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy/done", {62'b0, busy, done}, 64'd0);
    chk("reset hi:lo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset_n = 1; start = 0;

    foreach (vt[i]) normal($sformatf("vec%0d", i), vt[i].f, vt[i].a, vt[i].b, {vt[i].hi, vt[i].lo}, 0);
    prior = {vt[9].hi, vt[9].lo};

    run_op(MULDIV_MULTU, 32'd1000, 32'd1000, 0, 10, 0, first, bcnt, dcnt, res, snap);
    chk("flush busy/done", {62'b0, snap[65:64]}, 64'd0);
    chk("flush hi:lo hold", snap[63:0], prior);
    chk("flush no done", 64'(dcnt), 64'd0);

    @(negedge clk);
    start = 1; flush = 1; funct = MULDIV_MULTU; a = 3; b = 3;
    @(posedge clk); #1;
    start = 0; flush = 0;
    chk("start+flush idle busy", {63'b0, busy}, 64'd0);
    d = 0;
    repeat (40) begin
      if (done) d++;
      @(posedge clk); #1;
    end
    chk("start+flush no done", 64'(d), 64'd0);
    chk("start+flush hi:lo hold", {hi, lo}, prior);

    normal("restart ignored", MULDIV_DIVU, 32'd1000, 32'd33, model(MULDIV_DIVU, 32'd1000, 32'd33), 5);

    for (int i = 0; i < 25; i++) begin
      f = muldiv_e'(2'($urandom_range(0, 3)));
      x = $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      normal($sformatf("rand%0d f=%0d a=%h b=%h", i, f, x, y), f, x, y, model(f, x, y), 0);
    end

    run_op(MULDIV_MULT, 32'hDEADBEEF, 32'h12345, 0, 0, 20, first, bcnt, dcnt, res, snap);
    chk("mid-op reset outputs", {30'b0, snap}, 64'd0);
    chk("mid-op reset no done", 64'(dcnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
